// File: rtl/trace_capture_buffer_if.sv
// Bus bundle for trace_capture_buffer: capture inputs, read handshake and
// status flags. The master side drives samples and read requests; the
// slave side is the capture buffer itself.
interface trace_capture_buffer_if #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0]  sample_in;
  logic               sample_valid;
  logic [1:0]         mode;
  logic               arm;
  logic               rd_en;
  logic [DATA_W-1:0]  rd_data;
  logic [STAMP_W-1:0] rd_stamp;
  logic               rd_valid;
  logic [CNT_W-1:0]   count;
  logic               empty;
  logic               full;
  logic               armed;
  logic               overflow;
  logic               done;

  modport master (
    output sample_in, sample_valid, mode, arm, rd_en,
    input  rd_data, rd_stamp, rd_valid, count, empty, full, armed, overflow, done
  );

  modport slave (
    input  sample_in, sample_valid, mode, arm, rd_en,
    output rd_data, rd_stamp, rd_valid, count, empty, full, armed, overflow, done
  );
endinterface

// File: rtl/trace_capture_buffer.sv
// Ring-buffer trace capture: records an observation bus plus a free-running
// cycle stamp per entry, with off / every-valid / on-change / single-shot
// capture modes, drained through a registered one-cycle-latency read port.
module trace_capture_buffer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input logic                  clk,
  input logic                  reset,
  trace_capture_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_CHANGE = 2'd2;
  localparam logic [1:0] MODE_SINGLE = 2'd3;

  logic [DATA_W-1:0]  mem_data  [DEPTH];
  logic [STAMP_W-1:0] mem_stamp [DEPTH];

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_next;
  logic [STAMP_W-1:0] stamp;
  logic               armed_q;
  logic               overflow_q;
  logic               done_q;
  logic               have_last;
  logic [DATA_W-1:0]  last_value;
  logic [DATA_W-1:0]  rd_data_q;
  logic [STAMP_W-1:0] rd_stamp_q;
  logic               rd_valid_q;

  logic is_full;
  logic is_empty;
  logic wr_qual;
  logic wr_drop;
  logic wr_store;
  logic wr_overwrite;
  logic rd_fire;
  logic capture_end;

  assign is_full  = (count_q == FULL_COUNT);
  assign is_empty = (count_q == '0);

  // Decide this cycle's write/read actions; arm pre-empts both.
  always_comb begin
    wr_qual = armed_q && bus.sample_valid && (bus.mode != MODE_OFF) && !bus.arm &&
              ((bus.mode != MODE_CHANGE) || !have_last || (bus.sample_in != last_value));
    rd_fire      = bus.rd_en && !is_empty && !bus.arm;
    wr_drop      = wr_qual && (bus.mode == MODE_SINGLE) && is_full && !rd_fire;
    wr_store     = wr_qual && !wr_drop;
    wr_overwrite = wr_store && is_full && !rd_fire;
    count_next   = count_q;
    if (wr_store && !rd_fire && !is_full) begin
      count_next = count_q + CNT_W'(1);
    end else if (rd_fire && !wr_store) begin
      count_next = count_q - CNT_W'(1);
    end
    capture_end = wr_qual && (bus.mode == MODE_SINGLE) && (count_next == FULL_COUNT);
  end

  // Storage array holds no reset; validity is tracked purely by pointers and count.
  always_ff @(posedge clk) begin
    if (wr_store) begin
      mem_data[wr_ptr]  <= bus.sample_in;
      mem_stamp[wr_ptr] <= stamp;
    end
  end

  // Pointers, count, stamp, flags and the registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      stamp      <= '0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      have_last  <= 1'b0;
      last_value <= '0;
      rd_data_q  <= '0;
      rd_stamp_q <= '0;
      rd_valid_q <= 1'b0;
    end else if (bus.arm) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      stamp      <= '0;
      armed_q    <= 1'b1;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      have_last  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      stamp      <= stamp + STAMP_W'(1);
      count_q    <= count_next;
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q  <= mem_data[rd_ptr];
        rd_stamp_q <= mem_stamp[rd_ptr];
      end
      if (rd_fire || wr_overwrite) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (wr_qual) begin
        have_last  <= 1'b1;
        last_value <= bus.sample_in;
      end
      if (wr_overwrite) begin
        overflow_q <= 1'b1;
      end
      if (capture_end) begin
        armed_q <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_stamp = rd_stamp_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.armed    = armed_q;
  assign bus.overflow = overflow_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_trace_capture_buffer.sv
// Testbench for trace_capture_buffer: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_trace_capture_buffer;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int STAMP_W = 16;
  localparam int ENT_W   = DATA_W + STAMP_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  trace_capture_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STAMP_W(STAMP_W)) bus ();

  trace_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model state: the buffer is simply a queue of {data, stamp}.
  logic [ENT_W-1:0]   m_q[$];
  int                 m_stamp;
  bit                 m_armed, m_overflow, m_done, m_have_last, m_rd_valid;
  logic [DATA_W-1:0]  m_last;
  logic [DATA_W-1:0]  m_rd_data;
  logic [STAMP_W-1:0] m_rd_stamp;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelUpdate();
    bit wr, rd;
    logic [ENT_W-1:0] ent;
    if (reset) begin
      m_q.delete();
      m_stamp = 0; m_armed = 0; m_overflow = 0; m_done = 0; m_have_last = 0;
      m_last = '0; m_rd_valid = 0; m_rd_data = '0; m_rd_stamp = '0;
    end else if (bus.arm) begin
      m_q.delete();
      m_stamp = 0; m_armed = 1; m_overflow = 0; m_done = 0; m_have_last = 0;
      m_rd_valid = 0;
    end else begin
      wr = m_armed && bus.sample_valid && (bus.mode != 2'd0) &&
           ((bus.mode != 2'd2) || !m_have_last || (bus.sample_in != m_last));
      rd = bus.rd_en && (m_q.size() > 0);
      m_rd_valid = rd;
      if (rd) begin
        ent = m_q.pop_front();
        m_rd_data  = ent[ENT_W-1:STAMP_W];
        m_rd_stamp = ent[STAMP_W-1:0];
      end
      if (wr) begin
        m_have_last = 1;
        m_last = bus.sample_in;
        ent = {bus.sample_in, STAMP_W'(m_stamp)};
        if (bus.mode == 2'd3) begin
          if (m_q.size() < DEPTH) m_q.push_back(ent);
          if (m_q.size() == DEPTH) begin
            m_done = 1;
            m_armed = 0;
          end
        end else begin
          if (m_q.size() == DEPTH) begin
            void'(m_q.pop_front());
            m_overflow = 1;
          end
          m_q.push_back(ent);
        end
      end
      m_stamp = (m_stamp + 1) % (1 << STAMP_W);
    end
  endtask

  task automatic compareModel();
    checkOutput("count",    64'(bus.count),    64'(m_q.size()));
    checkOutput("empty",    64'(bus.empty),    64'(m_q.size() == 0));
    checkOutput("full",     64'(bus.full),     64'(m_q.size() == DEPTH));
    checkOutput("armed",    64'(bus.armed),    64'(m_armed));
    checkOutput("overflow", 64'(bus.overflow), 64'(m_overflow));
    checkOutput("done",     64'(bus.done),     64'(m_done));
    checkOutput("rd_valid", 64'(bus.rd_valid), 64'(m_rd_valid));
    checkOutput("rd_data",  64'(bus.rd_data),  64'(m_rd_data));
    checkOutput("rd_stamp", 64'(bus.rd_stamp), 64'(m_rd_stamp));
  endtask

  // One clock: advance model with the inputs the DUT will sample, then compare.
  task automatic applyStimulus();
    modelUpdate();
    @(posedge clk);
    #1;
    compareModel();
  endtask

  task automatic armMode(input logic [1:0] m);
    bus.mode = m;
    bus.arm = 1'b1;
    applyStimulus();
    bus.arm = 1'b0;
  endtask

  task automatic feed(input logic [DATA_W-1:0] v);
    bus.sample_valid = 1'b1;
    bus.sample_in = v;
    applyStimulus();
    bus.sample_valid = 1'b0;
  endtask

  task automatic readExpect(input string tag, input logic [DATA_W-1:0] d,
                            input logic [STAMP_W-1:0] s);
    bus.rd_en = 1'b1;
    applyStimulus();
    bus.rd_en = 1'b0;
    checkOutput({tag, "_valid"}, 64'(bus.rd_valid), 64'(1));
    checkOutput({tag, "_data"},  64'(bus.rd_data),  64'(d));
    checkOutput({tag, "_stamp"}, 64'(bus.rd_stamp), 64'(s));
  endtask

  initial begin
    bus.sample_in = '0;
    bus.sample_valid = 1'b0;
    bus.mode = 2'd0;
    bus.arm = 1'b0;
    bus.rd_en = 1'b0;

    // Reset state
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    checkOutput("rst_count", 64'(bus.count), 64'(0));
    checkOutput("rst_empty", 64'(bus.empty), 64'(1));
    checkOutput("rst_full",  64'(bus.full),  64'(0));
    checkOutput("rst_armed", 64'(bus.armed), 64'(0));
    checkOutput("rst_rdval", 64'(bus.rd_valid), 64'(0));
    checkOutput("rst_rddat", 64'(bus.rd_data), 64'(0));

    // Every-valid capture of three samples
    armMode(2'd1);
    feed(32'h11);
    feed(32'h22);
    feed(32'h33);
    checkOutput("t1_count", 64'(bus.count), 64'(3));
    readExpect("t1_r0", 32'h11, 16'd0);
    readExpect("t1_r1", 32'h22, 16'd1);
    readExpect("t1_r2", 32'h33, 16'd2);
    checkOutput("t1_empty", 64'(bus.empty), 64'(1));

    // On-change capture
    armMode(2'd2);
    feed(32'hA); feed(32'hA); feed(32'hA); feed(32'hB); feed(32'hB); feed(32'hA);
    checkOutput("t2_count", 64'(bus.count), 64'(3));
    readExpect("t2_r0", 32'hA, 16'd0);
    readExpect("t2_r1", 32'hB, 16'd3);
    readExpect("t2_r2", 32'hA, 16'd5);

    // Overwrite when full in every-valid mode
    armMode(2'd1);
    for (int i = 0; i < 18; i++) feed(32'(i));
    checkOutput("t3_full",     64'(bus.full),     64'(1));
    checkOutput("t3_count",    64'(bus.count),    64'(16));
    checkOutput("t3_overflow", 64'(bus.overflow), 64'(1));
    for (int i = 2; i < 18; i++) readExpect("t3_drain", 32'(i), 16'(i));
    checkOutput("t3_empty", 64'(bus.empty), 64'(1));

    // Single-shot stops when full
    armMode(2'd3);
    for (int i = 0; i < 20; i++) begin
      feed(32'(i));
      if (i == 14) checkOutput("t4_armed15", 64'(bus.armed), 64'(1));
      if (i == 15) begin
        checkOutput("t4_armed16", 64'(bus.armed), 64'(0));
        checkOutput("t4_done16",  64'(bus.done),  64'(1));
      end
    end
    checkOutput("t4_count", 64'(bus.count), 64'(16));
    for (int i = 0; i < 16; i++) readExpect("t4_drain", 32'(i), 16'(i));
    checkOutput("t4_empty", 64'(bus.empty), 64'(1));

    // Full with simultaneous read and write, then arm over a read
    armMode(2'd1);
    for (int i = 0; i < 16; i++) feed(32'(i));
    bus.rd_en = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_in = 32'h99;
    applyStimulus();
    bus.sample_valid = 1'b0;
    checkOutput("t5_rdval",    64'(bus.rd_valid), 64'(1));
    checkOutput("t5_rddat",    64'(bus.rd_data),  64'(0));
    checkOutput("t5_count",    64'(bus.count),    64'(16));
    checkOutput("t5_overflow", 64'(bus.overflow), 64'(0));
    bus.arm = 1'b1;
    applyStimulus();
    bus.arm = 1'b0;
    bus.rd_en = 1'b0;
    checkOutput("t5_arm_rdval", 64'(bus.rd_valid), 64'(0));
    checkOutput("t5_arm_count", 64'(bus.count),    64'(0));
    feed(32'h5A);
    readExpect("t5_restamp", 32'h5A, 16'd0);

    // Reset in the middle of a capture and a read
    armMode(2'd1);
    feed(32'h1); feed(32'h2); feed(32'h3);
    bus.rd_en = 1'b1;
    feed(32'h4);
    reset = 1'b1;
    feed(32'h5);
    reset = 1'b0;
    checkOutput("t6_count",    64'(bus.count),    64'(0));
    checkOutput("t6_armed",    64'(bus.armed),    64'(0));
    checkOutput("t6_rdval",    64'(bus.rd_valid), 64'(0));
    checkOutput("t6_overflow", 64'(bus.overflow), 64'(0));
    applyStimulus();
    bus.rd_en = 1'b0;
    checkOutput("t6_rd_after", 64'(bus.rd_valid), 64'(0));

    // Randomized traffic against the model
    bus.mode = 2'd1;
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 249) == 0);
      bus.arm = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom_range(0, 3));
      bus.sample_valid = ($urandom_range(0, 3) != 0);
      bus.sample_in = 32'($urandom_range(0, 3));
      bus.rd_en = ($urandom_range(0, 2) == 0);
      if (i % 100 == 0) bus.arm = 1'b1;
      applyStimulus();
    end
    reset = 1'b0;
    bus.arm = 1'b0;
    bus.rd_en = 1'b0;
    bus.sample_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
